// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU and the LSU.
// One transaction in flight; round-robin between simultaneous requesters.
// Optional response watchdog: define MEM_ARB_TIMEOUT_EN to build it in.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic                    ifu_resp_err,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int   MASK_W  = DATA_WIDTH / 8;
  localparam int   CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic SRC_IFU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_W-1:0]     wmask;
  } mreq_t;

  state_t state, state_nxt;
  mreq_t  lat;
  logic   owner, last_grant;
  logic   grant_ifu, grant_lsu;
  logic   timeout_hit, resp_fire, resp_err;

  // Round-robin pick in IDLE: a lone requester wins, a tie goes to whoever was not served last.
  // Readies are masked during reset so nothing is accepted while rst is high.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && !rst) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = (last_grant == SRC_LSU);
        grant_lsu = (last_grant == SRC_IFU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Counts silent WAIT cycles; held at 0 outside WAIT so every WAIT entry starts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               wait_cnt <= '0;
    else if (state != WAIT)                wait_cnt <= '0;
    else if (!mem_resp_valid && !timeout_hit) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  // The limit only matters when the watchdog is built in.
  logic [CNT_W-1:0] unused_timeout_limit;
  assign unused_timeout_limit = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  // A real response beats a watchdog expiry in the same cycle.
  assign resp_fire = mem_resp_valid || timeout_hit;
  assign resp_err  = timeout_hit && !mem_resp_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus memory-request and response steering.
  always_comb begin
    state_nxt      = state;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    unique case (state)
      IDLE: if (grant_ifu || grant_lsu) state_nxt = REQ;
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: if (resp_fire) begin
        state_nxt = IDLE;
        if (owner == SRC_IFU) begin
          ifu_resp_valid = 1'b1;
          ifu_rdata      = mem_resp_valid ? mem_rdata : '0;
          ifu_resp_err   = resp_err;
        end else begin
          lsu_resp_valid = 1'b1;
          lsu_rdata      = mem_resp_valid ? mem_rdata : '0;
          lsu_resp_err   = resp_err;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request; IFU fetches are reads with no data or mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat        <= '0;
      owner      <= SRC_IFU;
      last_grant <= SRC_LSU;
    end else if (grant_ifu) begin
      lat.addr   <= ifu_addr;
      lat.wen    <= 1'b0;
      lat.wdata  <= '0;
      lat.wmask  <= '0;
      owner      <= SRC_IFU;
      last_grant <= SRC_IFU;
    end else if (grant_lsu) begin
      lat.addr   <= lsu_addr;
      lat.wen    <= lsu_wen;
      lat.wdata  <= lsu_wdata;
      lat.wmask  <= lsu_wmask;
      owner      <= SRC_LSU;
      last_grant <= SRC_LSU;
    end
  end

  assign mem_addr  = lat.addr;
  assign mem_wen   = lat.wen;
  assign mem_wdata = lat.wdata;
  assign mem_wmask = lat.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0, ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_resp_valid, ifu_resp_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 1'b0, lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_wen = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_resp_valid, lsu_resp_err;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid, mem_wen;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Transaction model: one record for the request being serviced.
  bit            m_busy = 0, m_sent = 0;
  int            m_who = 0;     // 0 = IFU, 1 = LSU
  int            m_last = 1;    // requester served most recently
  int            m_silent = 0;  // silent WAIT cycles seen so far
  logic [AW-1:0] m_addr = '0;
  logic          m_wen = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [MW-1:0] m_wmask = '0;

  // Observation log for the directed literal checks.
  int            grant_log[$];
  int            ifu_resp_cnt = 0, lsu_resp_cnt = 0, mem_hs_cnt = 0;
  logic [DW-1:0] last_ifu_rdata = '0;
  logic          last_ifu_err = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic          hs_wen = 1'b0;
  logic [DW-1:0] hs_wdata = '0;
  logic [MW-1:0] hs_wmask = '0;

  // Compare DUT against the model, then advance the model and the log.
  always @(negedge clk) begin : cmp
    logic [6:0]    ec, gc;
    logic [DW-1:0] e_ird, e_lrd;
    int            win;
    bit            done, err;
    ec = '0; e_ird = '0; e_lrd = '0; win = -1; done = 0; err = 0;
    gc = {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, ifu_resp_err,
          lsu_resp_valid, lsu_resp_err};
    if (rst) begin
      m_busy = 0; m_sent = 0; m_last = 1; m_silent = 0;
      chk("reset_ctrl", {gc, ifu_rdata, lsu_rdata}, '0);
      chk("reset_mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
    end else begin
      if (!m_busy) begin
        if (ifu_req_valid && lsu_req_valid) win = (m_last == 1) ? 0 : 1;
        else if (ifu_req_valid)             win = 0;
        else if (lsu_req_valid)             win = 1;
        ec[6] = (win == 0);
        ec[5] = (win == 1);
      end else if (!m_sent) begin
        ec[4] = 1'b1;
      end else begin
        if (mem_resp_valid) done = 1;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (m_silent == TO) begin done = 1; err = 1; end
`endif
        if (done) begin
          if (m_who == 0) begin ec[3] = 1; ec[2] = err; e_ird = err ? '0 : mem_rdata; end
          else            begin ec[1] = 1; ec[0] = err; e_lrd = err ? '0 : mem_rdata; end
        end
      end
      chk("cycle_outputs", {gc, ifu_rdata, lsu_rdata}, {ec, e_ird, e_lrd});
      if (ec[4])
        chk("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask},
            {m_addr, m_wen, m_wdata, m_wmask});
      // advance model
      if (win == 0) begin
        m_busy = 1; m_sent = 0; m_who = 0; m_last = 0;
        m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
      end else if (win == 1) begin
        m_busy = 1; m_sent = 0; m_who = 1; m_last = 1;
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
      end else if (m_busy && !m_sent) begin
        if (mem_req_ready) begin m_sent = 1; m_silent = 0; end
      end else if (m_busy && m_sent) begin
        if (done) m_busy = 0;
        else      m_silent++;
      end
      // log what the DUT did
      if (ifu_req_valid && ifu_req_ready) grant_log.push_back(0);
      if (lsu_req_valid && lsu_req_ready) grant_log.push_back(1);
      if (mem_req_valid && mem_req_ready) begin
        mem_hs_cnt++; hs_addr = mem_addr; hs_wen = mem_wen; hs_wdata = mem_wdata; hs_wmask = mem_wmask;
      end
      if (ifu_resp_valid) begin ifu_resp_cnt++; last_ifu_rdata = ifu_rdata; last_ifu_err = ifu_resp_err; end
      if (lsu_resp_valid) lsu_resp_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    grant_log.delete();
    ifu_resp_cnt = 0; lsu_resp_cnt = 0; mem_hs_cnt = 0;
  endtask

  // Act as memory for one transaction: wait for the request (bounded), stall
  // rdly cycles, handshake, stay silent wdly WAIT cycles, then respond.
  task automatic serve(input int rdly, input int wdly, input logic [DW-1:0] rd, input bit drop);
    int n = 0;
    while (!mem_req_valid && n < 20) begin tick(); n++; end
    if (!mem_req_valid) begin
      chk("serve_req_timeout", 1, 0);
      return;
    end
    if (drop) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    repeat (rdly) tick();
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    repeat (wdly) tick();
    mem_resp_valid = 1; mem_rdata = rd; tick();
    mem_resp_valid = 0; mem_rdata = '0;
  endtask

  initial begin : stim
    logic [3:0] gv;
    repeat (2) tick();
    rst = 0;

    // Both valid right after reset: IFU first, then strict alternation.
    clear_log();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    serve(0, 0, 32'h1111_0001, 0);
    serve(1, 0, 32'h2222_0002, 0);
    serve(0, 1, 32'h3333_0003, 0);
    serve(0, 0, 32'h4444_0004, 0);
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick();
    gv = '0;
    for (int i = 0; i < grant_log.size() && i < 4; i++) gv[3-i] = grant_log[i][0];
    chk("rr_grant_count", grant_log.size(), 4);
    chk("rr_grant_order", gv, 4'b0101);

    // IFU fetch alone, two silent WAIT cycles.
    clear_log();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    serve(0, 2, 32'h0010_0073, 1);
    tick();
    chk("ifu_resp_cnt", ifu_resp_cnt, 1);
    chk("ifu_rdata", last_ifu_rdata, 32'h0010_0073);
    chk("ifu_no_lsu_resp", lsu_resp_cnt, 0);
    chk("ifu_mem_addr_wen", {hs_addr, hs_wen}, {32'h8000_0000, 1'b0});

    // LSU store with memory stalling three cycles.
    clear_log();
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    serve(3, 1, 32'h0, 1);
    lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    tick();
    chk("st_mem_hs_cnt", mem_hs_cnt, 1);
    chk("st_lsu_resp_cnt", lsu_resp_cnt, 1);
    chk("st_hs_fields", {hs_addr, hs_wen, hs_wdata, hs_wmask},
        {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});

    // Stray responses in IDLE and in REQ are ignored.
    clear_log();
    mem_resp_valid = 1; mem_rdata = 32'hBAD0_0001; tick();
    mem_resp_valid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; tick();
    ifu_req_valid = 0;
    mem_resp_valid = 1; mem_rdata = 32'hBAD0_0002; tick();
    mem_resp_valid = 0; mem_rdata = '0;
    chk("stray_no_resp", ifu_resp_cnt + lsu_resp_cnt, 0);
    serve(0, 0, 32'h0000_0013, 1);
    tick();
    chk("stray_then_ok", {ifu_resp_cnt[7:0], lsu_resp_cnt[7:0]}, 16'h0100);

    // Asynchronous reset while in WAIT.
    clear_log();
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; tick();
    lsu_req_valid = 0;
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    tick();
    #1 rst = 1;
    #1 chk("async_reset_outputs",
           {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, ifu_resp_err,
            lsu_resp_valid, lsu_resp_err, ifu_rdata, lsu_rdata,
            mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
    tick();
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 32'hCAFE_0000; tick();
    mem_resp_valid = 0; mem_rdata = '0;
    chk("late_resp_ignored", lsu_resp_cnt + ifu_resp_cnt, 0);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    serve(0, 0, 32'h0000_0297, 1);
    tick();
    chk("post_reset_service", {ifu_resp_cnt[7:0], last_ifu_rdata}, {8'd1, 32'h0000_0297});

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: error response after TO silent WAIT cycles.
    begin
      int n = 0;
      clear_log();
      ifu_req_valid = 1; ifu_addr = 32'h8000_00C0; tick();
      ifu_req_valid = 0;
      mem_req_ready = 1; tick(); mem_req_ready = 0;
      while (!ifu_resp_valid && n < 20) begin tick(); n++; end
      chk("to_wait_cycles", n, TO);
      chk("to_err_resp", {ifu_resp_valid, ifu_resp_err, ifu_rdata}, {1'b1, 1'b1, 32'h0});
      tick();
      chk("to_back_idle", mem_req_valid, 0);
    end
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
